// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2**N decoder with valid/ready request port and self-running scan mode.
// Define DECODER_SEQ_THERMO_EN for thermometer-coded out instead of one-hot.
module decoder_seq_nx2n #(
   parameter int unsigned N     = 3,
   parameter int unsigned DWELL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             in_valid,
   input  logic [N-1:0]     in,
   output logic             in_ready,
   output logic [2**N-1:0]  out,
   output logic             out_valid,
   output logic             wrap
);

   localparam int unsigned W  = 2 ** N;
   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);

   typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

   state_e        state_q;
   logic [N-1:0]  idx_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  idx_nxt;

   function automatic logic [W-1:0] code(input logic [N-1:0] i);
      logic [W-1:0] r;
      r = '0;
      for (int b = 0; b < int'(W); b++) begin
`ifdef DECODER_SEQ_THERMO_EN
         r[b] = (b <= int'(i));
`else
         r[b] = (b == int'(i));
`endif
      end
      return r;
   endfunction

   assign idx_nxt  = idx_q + N'(1);
   assign in_ready = en & (state_q != StScan) & ~rst;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         cnt_q     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         unique case (state_q)
            StIdle, StDirect: begin
               if (in_valid) begin
                  idx_q     <= in;
                  cnt_q     <= '0;
                  out       <= code(in);
                  out_valid <= 1'b1;
                  state_q   <= mode ? StScan : StDirect;
               end
            end
            StScan: begin
               // Advance on the last dwell cycle so each index is shown exactly DWELL cycles.
               if (cnt_q == CntLast) begin
                  cnt_q <= '0;
                  idx_q <= idx_nxt;
                  out   <= code(idx_nxt);
                  wrap  <= &idx_q;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// Self-checking bench for decoder_seq_nx2n (N=3, DWELL=2): arithmetic model plus literal pins.
module tb_decoder_seq_nx2n;

   localparam int N     = 3;
   localparam int DWELL = 2;
   localparam int W     = 2 ** N;

   logic         clk = 1'b0;
   logic         rst, en, mode, in_valid;
   logic [N-1:0] in;
   logic         in_ready, out_valid, wrap;
   logic [W-1:0] out;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   // Model: what was last accepted and how many cycles a scan has been running.
   int m_kind = 0;  // 0 none, 1 direct, 2 scan
   int m_idx  = 0;
   int m_el   = 0;

   decoder_seq_nx2n #(.N(N), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in(in),
      .in_ready(in_ready), .out(out), .out_valid(out_valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] m_code(input int i);
`ifdef DECODER_SEQ_THERMO_EN
      return W'((2 << i) - 1);
`else
      return W'(1 << i);
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst || !en) m_kind = 0;
      else if (m_kind != 2 && in_valid) begin
         m_kind = mode ? 2 : 1;
         m_idx  = int'(in);
         m_el   = 0;
      end else if (m_kind == 2) m_el++;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         int cur;
         logic [W-1:0] e_out;
         logic e_wrap;
         cur    = (m_idx + m_el / DWELL) % W;
         e_out  = (m_kind == 0) ? '0 : m_code((m_kind == 1) ? m_idx : cur);
         e_wrap = (m_kind == 2) && (m_el > 0) && (m_el % DWELL == 0) && (cur == 0);
         chk("m_out", 64'(out), 64'(e_out));
         chk("m_out_valid", 64'(out_valid), 64'(m_kind != 0));
         chk("m_wrap", 64'(wrap), 64'(e_wrap));
         chk("m_in_ready", 64'(in_ready), 64'(en && !rst && m_kind != 2));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      chk_on = 1'b1;
   endtask

   logic [W-1:0] dir_tab  [8];
   logic [W-1:0] scan_tab [6];
   logic         wrap_tab [6];
   logic [W-1:0] mid5, dir1;

   initial begin
`ifdef DECODER_SEQ_THERMO_EN
      dir_tab  = '{8'h01, 8'h03, 8'h07, 8'h0f, 8'h1f, 8'h3f, 8'h7f, 8'hff};
      scan_tab = '{8'h7f, 8'h7f, 8'hff, 8'hff, 8'h01, 8'h01};
      mid5     = 8'h3f;
      dir1     = 8'h03;
`else
      dir_tab  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      scan_tab = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01};
      mid5     = 8'h20;
      dir1     = 8'h02;
`endif
      wrap_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in = '0;
      repeat (2) step();
      chk("rst_out", 64'(out), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(in_ready), 64'h1);

      // Direct decode, back-to-back accepts.
      for (int i = 0; i < W; i++) begin
         in_valid = 1'b1; mode = 1'b0; in = N'(i);
         step();
         chk("direct_out", 64'(out), 64'(dir_tab[i]));
      end
      in_valid = 1'b0;
      step();
      chk("direct_hold", 64'(out), 64'(dir_tab[7]));

      // Scan from 6 through the wrap.
      in_valid = 1'b1; mode = 1'b1; in = 3'd6;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("scan_out", 64'(out), 64'(scan_tab[k]));
         chk("scan_wrap", 64'(wrap), 64'(wrap_tab[k]));
         chk("scan_ready", 64'(in_ready), 64'h0);
         if (k == 2) begin in_valid = 1'b1; mode = 1'b0; in = 3'd2; end
         step();
      end
      in_valid = 1'b0;

      // Drop en with a competing request.
      en = 1'b0; in_valid = 1'b1; mode = 1'b0; in = 3'd3;
      step();
      chk("en_low_out", 64'(out), 64'h0);
      chk("en_low_valid", 64'(out_valid), 64'h0);
      en = 1'b1; in_valid = 1'b0;
      #1;
      chk("reen_ready", 64'(in_ready), 64'h1);
      step();
      chk("reen_no_resume", 64'(out), 64'h0);

      // Reset mid-scan at index 5.
      in_valid = 1'b1; mode = 1'b1; in = 3'd4;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      chk("mid_idx5", 64'(out), 64'(mid5));
      rst = 1'b1;
      step();
      chk("mid_rst_out", 64'(out), 64'h0);
      rst = 1'b0; in_valid = 1'b1; mode = 1'b0; in = 3'd1;
      step();
      chk("post_rst_direct", 64'(out), 64'(dir1));

      // Full sweep from 0, with ignored requests along the way.
      in_valid = 1'b1; mode = 1'b1; in = 3'd0;
      step();
      for (int k = 0; k < 2 * DWELL * W + 3; k++) begin
         in_valid = (k % 3 == 0); mode = 1'b0; in = N'(k);
         step();
      end
      in_valid = 1'b0; en = 1'b0;
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
